// File: rtl/display_pixel_feeder.sv
// Pixel FIFO between the loader/blur stage and the video encoder. It paces loader reads
// and places the grayscale image window onto the active raster as 24-bit RGB.
module display_pixel_feeder #(
  parameter int IMG_W      = 225,
  parameter int IMG_H      = 225,
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter int CW         = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int SLACK      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vsync,
  input  logic          i_de,
  input  logic [CW-1:0] i_x,
  input  logic [CW-1:0] i_y,
  input  logic [7:0]    i_data,
  input  logic          i_valid,
  output logic          o_next,
  output logic [23:0]   o_rgb,
  output logic          o_de,
  output logic          o_underflow,
  output logic          o_overflow
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = $clog2(NPIX + 1);

  localparam logic [CW:0] X_LO = (CW+1)'(X0);
  localparam logic [CW:0] X_HI = (CW+1)'(X0 + IMG_W);
  localparam logic [CW:0] Y_LO = (CW+1)'(Y0);
  localparam logic [CW:0] Y_HI = (CW+1)'(Y0 + IMG_H);
  localparam logic [AW:0] NEXT_TH = (AW+1)'(FIFO_DEPTH - SLACK);
  localparam logic [AW:0] FULL_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_POP = PW'(NPIX - 1);

  typedef enum logic [1:0] {S_FLUSH, S_FILL, S_RUN, S_DONE} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [PW-1:0] pop_cnt;

  logic in_win, active, pop, empty, full, rd_ok, wr, ovf_set, unf_set, last_pop;

  always_comb begin
    in_win   = i_de
             & ({1'b0, i_x} >= X_LO) & ({1'b0, i_x} < X_HI)
             & ({1'b0, i_y} >= Y_LO) & ({1'b0, i_y} < Y_HI);
    active   = (state == S_FILL) || (state == S_RUN);
    pop      = i_vsync & active & in_win;
    empty    = (cnt == '0);
    full     = (cnt == FULL_C);
    rd_ok    = pop & ~empty;
    // A pop from a full FIFO frees the slot the simultaneous push lands in.
    wr       = i_vsync & i_valid & (~full | rd_ok);
    ovf_set  = i_vsync & i_valid & full & ~pop;
    unf_set  = pop & empty;
    last_pop = pop & (pop_cnt == LAST_POP);
    o_next   = i_vsync & active & (cnt <= NEXT_TH);
  end

  always_comb begin
    state_n = state;
    if (!i_vsync) state_n = S_FLUSH;
    else begin
      case (state)
        S_FLUSH: state_n = S_FILL;
        S_FILL:  if (pop) state_n = last_pop ? S_DONE : S_RUN;
        S_RUN:   if (last_pop) state_n = S_DONE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FLUSH;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      pop_cnt     <= '0;
      o_underflow <= 1'b0;
      o_overflow  <= 1'b0;
      o_rgb       <= '0;
      o_de        <= 1'b0;
    end else begin
      state <= state_n;
      o_de  <= i_de;
      o_rgb <= rd_ok ? {3{mem[rd_ptr]}} : 24'h0;
      if (!i_vsync) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        cnt         <= '0;
        pop_cnt     <= '0;
        o_underflow <= 1'b0;
        o_overflow  <= 1'b0;
      end else begin
        if (wr)    wr_ptr <= wr_ptr + 1'b1;
        if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        case ({wr, rd_ok})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
        // Underflowed pops still advance so the raster position stays in step.
        if (pop) pop_cnt <= pop_cnt + 1'b1;
        if (unf_set) o_underflow <= 1'b1;
        if (ovf_set) o_overflow  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= i_data;
  end

endmodule

// File: tb/tb_display_pixel_feeder.sv
// Directed bench for display_pixel_feeder using a 6x3 image window at (10,4).
module tb_display_pixel_feeder;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n, vsync, de, vdrv, ldr_en;
  logic [CW-1:0] x, y;
  logic [7:0]    data;
  logic          valid, o_next, o_de, o_underflow, o_overflow;
  logic [23:0]   o_rgb;
  logic [4:0]    lpipe;

  int total = 0;
  int bad   = 0;
  int k;

  always #5 clk = ~clk;

  // Loader model: a request accepted on o_next returns data five cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lpipe <= '0;
    else        lpipe <= {lpipe[3:0], o_next};
  end
  assign valid = ldr_en ? lpipe[4] : vdrv;

  display_pixel_feeder #(
    .IMG_W(6), .IMG_H(3), .X0(10), .Y0(4), .CW(CW), .FIFO_DEPTH(16), .SLACK(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_vsync(vsync), .i_de(de), .i_x(x), .i_y(y),
    .i_data(data), .i_valid(valid), .o_next(o_next), .o_rgb(o_rgb), .o_de(o_de),
    .o_underflow(o_underflow), .o_overflow(o_overflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    vdrv = 1'b1;
    data = d;
    tick();
    vdrv = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b1; de = 1'b0; x = '0; y = '0;
    data = '0; vdrv = 1'b0; ldr_en = 1'b0;
    #12;
    chk("rst_next", 32'(o_next), 32'd0);
    chk("rst_rgb", 32'(o_rgb), 32'd0);
    chk("rst_de", 32'(o_de), 32'd0);
    chk("rst_unf", 32'(o_underflow), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("fill_next", 32'(o_next), 32'd1);

    // Pacing against a latent loader
    ldr_en = 1'b1;
    repeat (30) tick();
    chk("pace_next", 32'(o_next), 32'd0);
    chk("pace_ovf", 32'(o_overflow), 32'd0);
    ldr_en = 1'b0;

    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    chk("refill_next", 32'(o_next), 32'd1);

    // Fill to the request threshold, then to full
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    chk("cnt8_next", 32'(o_next), 32'd1);
    push(8'h18);
    chk("cnt9_next", 32'(o_next), 32'd0);
    for (int i = 9; i < 16; i++) push(8'(8'h10 + i));
    chk("full_ovf0", 32'(o_overflow), 32'd0);

    // Window edges
    de = 1'b1; x = 12'd9; y = 12'd4;
    tick();
    chk("x9_rgb", 32'(o_rgb), 32'd0);
    chk("x9_de", 32'(o_de), 32'd1);
    x = 12'd10; y = 12'd3;
    tick();
    chk("y3_rgb", 32'(o_rgb), 32'd0);

    // First window pixel pops while a push lands on a full FIFO
    x = 12'd10; y = 12'd4; vdrv = 1'b1; data = 8'h20;
    tick();
    chk("first_px", 32'(o_rgb), 32'h101010);
    chk("pushpop_ovf", 32'(o_overflow), 32'd0);
    de = 1'b0; data = 8'h21;
    tick();
    vdrv = 1'b0;
    chk("drop_ovf", 32'(o_overflow), 32'd1);
    chk("drop_de", 32'(o_de), 32'd0);

    // Remaining 17 window pixels: 0x11..0x20, then one underflow
    k = 0;
    for (int yy = 4; yy <= 6; yy++) begin
      for (int xx = 10; xx <= 15; xx++) begin
        if (!(yy == 4 && xx == 10)) begin
          de = 1'b1; x = 12'(xx); y = 12'(yy);
          k++;
          tick();
          chk($sformatf("px%0d", k), 32'(o_rgb), (k <= 16) ? 32'h10101 * (32'h10 + 32'(k)) : 32'd0);
          if (k == 11) chk("run_next", 32'(o_next), 32'd1);
          if (k == 16) chk("unf_pre", 32'(o_underflow), 32'd0);
        end
      end
      if (yy == 4) begin
        x = 12'd16;
        tick();
        chk("x16_rgb", 32'(o_rgb), 32'd0);
      end
    end
    de = 1'b0;
    chk("unf_last", 32'(o_underflow), 32'd1);
    chk("done_next", 32'(o_next), 32'd0);

    // Done: pushes accepted, window stays black
    push(8'hAA);
    de = 1'b1; x = 12'd10; y = 12'd4;
    tick();
    de = 1'b0;
    chk("done_black", 32'(o_rgb), 32'd0);
    chk("sticky_unf", 32'(o_underflow), 32'd1);
    chk("sticky_ovf", 32'(o_overflow), 32'd1);

    // Frame flush clears flags; mid-fill abort discards buffered words
    vsync = 1'b0;
    tick();
    chk("vs_unf", 32'(o_underflow), 32'd0);
    chk("vs_ovf", 32'(o_overflow), 32'd0);
    vsync = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) push(8'(8'h40 + i));
    chk("seven_next", 32'(o_next), 32'd1);
    vsync = 1'b0;
    #1;
    chk("vs_next_comb", 32'(o_next), 32'd0);
    tick();
    vsync = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
    chk("fresh_cnt8", 32'(o_next), 32'd1);
    push(8'h58);
    chk("fresh_cnt9", 32'(o_next), 32'd0);
    de = 1'b1; x = 12'd10; y = 12'd4;
    tick();
    de = 1'b0;
    chk("fresh_first", 32'(o_rgb), 32'h505050);
    chk("fresh_de", 32'(o_de), 32'd1);

    // Asynchronous reset between clock edges
    #3 rst_n = 1'b0;
    #1;
    chk("arst_rgb", 32'(o_rgb), 32'd0);
    chk("arst_de", 32'(o_de), 32'd0);
    chk("arst_next", 32'(o_next), 32'd0);
    chk("arst_flags", {30'd0, o_underflow, o_overflow}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
